// File: rtl/sram_input_ctrl.sv
// Shares the 2048x32 input SRAM between a host write port and a burst reader.
// Reads return one cycle after grant; writes complete on grant; no read backpressure.
module sram_input_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic              last_grant_w;
  logic              req_w, req_r, gnt_w, gnt_r;
  logic              done_set, last_set;
  logic              dv_q, last_q, done_q;

  // Round-robin: on conflict the requester that lost last time wins.
  always_comb begin
    req_w = wr_valid && !reset;
    req_r = (state == BURST) && !reset;
    gnt_w = req_w && (!req_r || !last_grant_w);
    gnt_r = req_r && (!req_w || last_grant_w);
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    done_set      = 1'b0;
    last_set      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) begin
          if (rd_len == '0) begin
            done_set = 1'b1;
          end else begin
            cur_addr_nxt  = rd_base;
            remaining_nxt = rd_len;
            state_nxt     = BURST;
          end
        end
      end
      BURST: begin
        if (gnt_r) begin
          cur_addr_nxt  = cur_addr + ADDR_W'(1);
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_nxt = DRAIN;
            last_set  = 1'b1;
            done_set  = 1'b1;
          end
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data buses hold their last driven value when the SRAM is idle.
  always_comb begin
    sram_cen = !(gnt_w || gnt_r);
    sram_wen = !gnt_w;
    if (reset)      sram_a = '0;
    else if (gnt_w) sram_a = wr_addr;
    else if (gnt_r) sram_a = cur_addr;
    else            sram_a = a_q;
    if (reset)      sram_d = '0;
    else if (gnt_w) sram_d = wr_data;
    else            sram_d = d_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      last_grant_w <= 1'b0;
      a_q          <= '0;
      d_q          <= '0;
      dv_q         <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      if (gnt_w || gnt_r) begin
        last_grant_w <= gnt_w;
        a_q          <= sram_a;
      end
      if (gnt_w) d_q <= wr_data;
      dv_q   <= gnt_r;
      last_q <= last_set;
      done_q <= done_set;
    end
  end

  // Registered flags are masked while reset is held so an aborted burst leaves no trace.
  assign wr_ready      = gnt_w;
  assign rd_busy       = (state != IDLE) && !reset;
  assign rd_data_valid = dv_q && !reset;
  assign rd_last       = last_q && !reset;
  assign rd_done       = done_q && !reset;
  assign rd_data       = sram_q;

endmodule

// File: doc/sram_input_ctrl.md
Name: sram_input_ctrl

Overview:
Single-port controller for the 2048x32 input activation SRAM. It shares the SRAM between two requesters. The first is a host loader that writes single words through a valid/ready handshake. The second is a compute-side burst reader that requests N consecutive words and receives them as a stream. The block drives the SRAM's active-low CEN/WEN, address and data, arbitrates round-robin on conflict, and tracks the 1-cycle read latency.

Parameters:
ADDR_W, 11, SRAM address width (depth 2^ADDR_W)
DATA_W, 32, word width
LEN_W, 12, burst length width (max length 2^ADDR_W)

Ports:
CLK  in  1  clock; all state updates on rising edge
reset  in  1  synchronous reset, active-high
wr_valid  in  1  loader has a write pending
wr_ready  out  1  write granted this cycle; transfer when wr_valid&&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_start  in  1  one-cycle pulse to begin a burst; ignored while rd_busy
rd_base  in  ADDR_W  burst start address, sampled with rd_start
rd_len  in  LEN_W  burst word count, sampled with rd_start
rd_busy  out  1  burst in progress (BURST or DRAIN)
rd_data_valid  out  1  rd_data carries a burst word this cycle
rd_data  out  DATA_W  read word (pass-through of sram_q)
rd_last  out  1  with rd_data_valid, marks the final word
rd_done  out  1  one-cycle pulse at burst completion
sram_cen  out  1  SRAM chip enable, active low
sram_wen  out  1  SRAM write enable, active low (low = write)
sram_a  out  ADDR_W  SRAM address
sram_d  out  DATA_W  SRAM write data
sram_q  in  DATA_W  SRAM read data; valid the cycle after a read is issued

Behaviour:
- Reset:
  - FSM goes to IDLE; counters clear; last_grant clears to READ, so a first conflict goes to the write.
  - During and after reset: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0, wr_ready=0, rd_busy=0, rd_data_valid=0, rd_last=0, rd_done=0.
  - Reset during a burst aborts it: no rd_done, and any pending rd_data_valid is dropped.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - rd_start with rd_len>=1: latch cur_addr=rd_base and remaining=rd_len, then go to BURST.
  - rd_start with rd_len=0: no SRAM access; rd_done pulses the next cycle; stay in IDLE with rd_busy=0.
- BURST:
  - A read request is active every cycle.
  - When the read is granted: SRAM read at cur_addr, then cur_addr+1 (wraps modulo 2^ADDR_W, 2047->0) and remaining-1.
  - Granted with remaining==1: go to DRAIN.
- DRAIN: one cycle only. It presents the final word with rd_last=1 and pulses rd_done, then returns to IDLE. rd_start is accepted again the cycle after DRAIN.
- Arbitration (combinational, one access per cycle):
  - Only one requester active: it is granted.
  - Both active: grant the one not granted last; last_grant updates on every grant.
  - wr_ready = wr_valid && write granted.
- SRAM drive (combinational from the grant; sampled by the SRAM at the next edge):
  - Write grant: cen=0, wen=0, a=wr_addr, d=wr_data.
  - Read grant: cen=0, wen=1, a=cur_addr.
  - No grant: cen=1, wen=1, a and d hold their last values.
- Read latency: rd_data_valid is a register set the cycle after each read grant, with rd_data=sram_q in that cycle. Words arrive in address order. Write-granted cycles inside a burst create gaps in rd_data_valid. There is no backpressure on the read stream; the consumer must accept every valid word.
- Ordering: a write to an address not yet read in the active burst is visible to that burst if it is granted before the read of that address.
- Max burst: rd_len=2048 reads every location exactly once, wrapping from rd_base.

Test Plan:
- Reset then idle: hold reset 3 cycles -> sram_cen=1, wr_ready=0, rd_busy=0; no SRAM access for 5 idle cycles.
- Write-only: wr_valid with addr 5,6,7 and data 0xA,0xB,0xC over 3 cycles, no burst -> wr_ready=1 each cycle; sram_wen=0 with matching a/d; memory model holds the values.
- Burst read: preload mem[i]=i+0x100; rd_start with base=10, len=4 -> rd_data_valid on 4 consecutive cycles starting 2 cycles after rd_start, data 0x10A..0x10D; rd_last and rd_done on the 4th word; rd_busy drops the next cycle.
- Conflict: wr_valid held constant during a len=4 burst -> grants alternate W,R,W,R starting with W; burst completes in 8 cycles; writes accepted 4 times.
- Wrap and edge lengths:
  - base=2046, len=4 -> addresses 2046, 2047, 0, 1.
  - len=0 -> rd_done 1 cycle later with no cen=0.
  - rd_start during busy -> ignored.
- Reset mid-burst: reset asserted after 2 of 6 words -> no further rd_data_valid, no rd_done; a new burst after reset works correctly.
